// File: rtl/instr_mem_axi_rd_slave.sv
// rtl/instr_mem_axi_rd_slave.sv - AXI4 read-only slave streaming instruction BRAM words with a 2-entry skid buffer
// Optional: define IMEM_ADDR_RANGE_CHECK_EN to return DECERR for bursts outside the mapped window.
module instr_mem_axi_rd_slave #(
   parameter int ADDR_SIZE = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH = 1024,
   parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
   input  logic                         i_clk,
   input  logic                         i_areset_n,
   input  logic                         arvalid_i,
   input  logic [ADDR_SIZE-1:0]         araddr_i,
   input  logic [7:0]                   arlen_i,
   input  logic [2:0]                   arsize_i,
   input  logic [1:0]                   arburst_i,
   output logic                         arready_o,
   output logic                         rvalid_o,
   output logic [DATA_WIDTH-1:0]        rdata_o,
   output logic [1:0]                   rresp_o,
   output logic                         rlast_o,
   input  logic                         rready_i,
   output logic                         awready_o,
   output logic                         wready_o,
   output logic                         bvalid_o,
   output logic [1:0]                   bresp_o,
   output logic                         o_mem_en,
   output logic [$clog2(MEM_DEPTH)-1:0] o_mem_addr,
   input  logic [DATA_WIDTH-1:0]        i_mem_rdata
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_FIXED = 2'b00, BURST_INCR = 2'b01;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                state_q, state_d;
   logic                  arready_q, arready_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic                  fixed_q, fixed_d;
   logic                  err_q, err_d;
   logic                  dec_q, dec_d;
   logic [8:0]            issue_q, issue_d;
   logic [8:0]            beat_q, beat_d;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            cnt_q;

   logic                  mem_en, fifo_empty, rvalid, pop, push, fifo_pop, last_beat, range_bad;
   logic [DATA_WIDTH-1:0] head;
   logic [ADDR_SIZE-1:0]  byte_off;
   logic                  unused_off;

   assign byte_off   = araddr_i - BASE_ADDR;
   assign unused_off = &{1'b0, byte_off[ADDR_SIZE-1:AW+2], byte_off[1:0]};

`ifdef IMEM_ADDR_RANGE_CHECK_EN
   localparam logic [ADDR_SIZE+1:0] LIMIT = (ADDR_SIZE+2)'(BASE_ADDR) + (ADDR_SIZE+2)'(4 * MEM_DEPTH);
   logic [ADDR_SIZE+1:0] end_byte;
   // Start address of the final beat; FIXED bursts never leave the start word.
   assign end_byte  = {2'b00, araddr_i} +
                      ((arburst_i == BURST_FIXED) ? '0 : (ADDR_SIZE+2)'({arlen_i, 2'b00}));
   assign range_bad = (araddr_i < BASE_ADDR) || (end_byte >= LIMIT);
`else
   assign range_bad = 1'b0;
`endif

   // Returning BRAM data bypasses the buffer when it is empty, giving first beat at T+2.
   assign fifo_empty = (cnt_q == 2'd0);
   assign rvalid     = !fifo_empty || inflight_q;
   assign head       = fifo_empty ? i_mem_rdata : fifo_q[rd_ptr_q];
   assign pop        = rvalid && rready_i;
   assign fifo_pop   = pop && !fifo_empty;
   assign push       = inflight_q && !(fifo_empty && pop);
   assign last_beat  = (beat_q == {1'b0, len_q});

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      fixed_d = fixed_q;
      err_d   = err_q;
      dec_d   = dec_q;
      issue_d = issue_q;
      beat_d  = beat_q;
      mem_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (arvalid_i && arready_q) begin
               addr_d  = byte_off[AW+1:2];
               len_d   = arlen_i;
               fixed_d = (arburst_i == BURST_FIXED);
               err_d   = (arsize_i != 3'd2) ||
                         ((arburst_i != BURST_FIXED) && (arburst_i != BURST_INCR));
               dec_d   = range_bad;
               issue_d = {1'b0, arlen_i} + 9'd1;
               beat_d  = '0;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            // Reads in flight plus buffered beats never exceed the two buffer slots.
            mem_en = (issue_q != 9'd0) && (({1'b0, cnt_q} + {2'b00, inflight_q}) < 3'd2);
            if (mem_en) begin
               issue_d = issue_q - 9'd1;
               if (!fixed_q) addr_d = addr_q + AW'(1);
            end
            if (pop) begin
               beat_d = beat_q + 9'd1;
               if (last_beat) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      arready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         state_q    <= S_IDLE;
         arready_q  <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         fixed_q    <= 1'b0;
         err_q      <= 1'b0;
         dec_q      <= 1'b0;
         issue_q    <= '0;
         beat_q     <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         arready_q  <= arready_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         fixed_q    <= fixed_d;
         err_q      <= err_d;
         dec_q      <= dec_d;
         issue_q    <= issue_d;
         beat_q     <= beat_d;
         inflight_q <= mem_en;
         if (push) wr_ptr_q <= !wr_ptr_q;
         if (fifo_pop) rd_ptr_q <= !rd_ptr_q;
         cnt_q      <= cnt_q + {1'b0, push} - {1'b0, fifo_pop};
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) fifo_q[wr_ptr_q] <= i_mem_rdata;
   end

   assign arready_o  = arready_q;
   assign rvalid_o   = rvalid;
   assign rlast_o    = rvalid && last_beat;
   assign rresp_o    = !rvalid ? RESP_OKAY :
                       err_q   ? RESP_SLVERR :
                       dec_q   ? RESP_DECERR : RESP_OKAY;
   assign rdata_o    = (rvalid && !err_q && !dec_q) ? head : '0;
   assign o_mem_en   = mem_en;
   assign o_mem_addr = addr_q;
   assign awready_o  = 1'b0;
   assign wready_o   = 1'b0;
   assign bvalid_o   = 1'b0;
   assign bresp_o    = RESP_OKAY;
endmodule

// File: tb/tb_instr_mem_axi_rd_slave.sv
// tb/tb_instr_mem_axi_rd_slave.sv - directed self-checking bench for instr_mem_axi_rd_slave
module tb_instr_mem_axi_rd_slave;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arvalid = 1'b0;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = 3'd2;
   logic [1:0]  arburst = 2'b01;
   logic        arready;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rready = 1'b1;
   logic        awready, wready, bvalid;
   logic [1:0]  bresp;
   logic        mem_en;
   logic [9:0]  mem_addr;
   logic [31:0] mem_rdata = '0;

   logic [31:0] bram [1024];
   int          cyc = 0;
   int          issued = 0, popped = 0;
   int          aw_viol = 0;
   int          n_assert = 0, n_fail = 0;

   logic [31:0] got_data [16];
   logic [1:0]  got_resp [16];
   logic        got_last [16];
   int          got_cyc  [16];
   int          nbeats, stall_viol, max_occ;
   bit          done;
   logic [5:0]  pat = 6'b101001;

   instr_mem_axi_rd_slave dut (
      .i_clk(clk), .i_areset_n(rst_n),
      .arvalid_i(arvalid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
      .arburst_i(arburst), .arready_o(arready),
      .rvalid_o(rvalid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rready_i(rready),
      .awready_o(awready), .wready_o(wready), .bvalid_o(bvalid), .bresp_o(bresp),
      .o_mem_en(mem_en), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en) mem_rdata <= bram[mem_addr];
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued <= 0;
         popped <= 0;
      end else begin
         if (mem_en) issued <= issued + 1;
         if (rvalid && rready) popped <= popped + 1;
      end
   end

   always @(negedge clk) if (awready || wready || bvalid) aw_viol <= aw_viol + 1;

   task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, output int t);
      @(negedge clk);
      arvalid = 1'b1; araddr = a; arlen = l; arsize = s; arburst = b;
      t = -1;
      for (int i = 0; i < 20; i++) begin
         if (arready) begin t = cyc; break; end
         @(negedge clk);
      end
      if (t < 0) begin
         n_assert++; n_fail++;
         $display("FAIL ar_handshake: arready never rose within 20 cycles");
      end
      @(posedge clk);
      #1 arvalid = 1'b0;
   endtask

   // Collects handshaken beats; mode 0 keeps rready high, mode 1 plays the toggle pattern.
   task automatic collect(input int mode);
      logic [31:0] hd; logic [1:0] hr; logic hl; bit have_hold; int occ;
      nbeats = 0; stall_viol = 0; max_occ = 0; done = 0; have_hold = 0;
      for (int i = 0; i < 16; i++) begin
         got_data[i] = 'x; got_resp[i] = 'x; got_last[i] = 1'bx; got_cyc[i] = -1;
      end
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         rready = (mode == 0) ? 1'b1 : pat[c % 6];
         occ = issued - popped;
         if (occ > max_occ) max_occ = occ;
         if (have_hold && (rvalid !== 1'b1 || rdata !== hd || rresp !== hr || rlast !== hl))
            stall_viol++;
         have_hold = 0;
         if (rvalid && !rready) begin
            hd = rdata; hr = rresp; hl = rlast; have_hold = 1;
         end
         if (rvalid && rready && nbeats < 16) begin
            got_data[nbeats] = rdata; got_resp[nbeats] = rresp;
            got_last[nbeats] = rlast; got_cyc[nbeats] = cyc;
            nbeats++;
            if (rlast) begin done = 1; break; end
         end
      end
      if (!done) begin
         n_assert++; n_fail++;
         $display("FAIL burst_timeout: last beat not seen, beats=%0d", nbeats);
      end
      @(posedge clk);
      #1 rready = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_assert++;
      if (arready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || rresp !== 2'b00 ||
          rdata !== 32'h0 || mem_en !== 1'b0 || mem_addr !== 10'h0) begin
         n_fail++;
         $display("FAIL reset_values: arready=%b rvalid=%b rlast=%b rresp=%b rdata=%h en=%b addr=%h, required all 0",
                  arready, rvalid, rlast, rresp, rdata, mem_en, mem_addr);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_assert++;
      if (arready !== 1'b1) begin
         n_fail++; $display("FAIL arready_after_reset: got %b required 1", arready);
      end
   endtask

   task automatic test_incr_basic;
      int t;
      ar_send(32'h10, 8'd3, 3'd2, 2'b01, t);
      collect(0);
      n_assert++;
      if (nbeats !== 4) begin n_fail++; $display("FAIL incr_count: got %0d required 4", nbeats); end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (got_data[i] !== 32'hA500_0004 + i || got_resp[i] !== 2'b00 ||
             got_last[i] !== (i == 3) || got_cyc[i] !== t + 2 + i) begin
            n_fail++;
            $display("FAIL incr_beat%0d: data=%h resp=%b last=%b cyc=%0d required data=%h resp=00 last=%b cyc=%0d",
                     i, got_data[i], got_resp[i], got_last[i], got_cyc[i], 32'hA500_0004 + i, (i == 3), t + 2 + i);
         end
      end
      n_assert++;
      if (arready !== 1'b1 || cyc !== t + 6) begin
         n_fail++; $display("FAIL incr_arready_return: arready=%b cyc=%0d required 1 at %0d", arready, cyc, t + 6);
      end
   endtask

   task automatic test_backpressure;
      int t;
      ar_send(32'h10, 8'd3, 3'd2, 2'b01, t);
      collect(1);
      n_assert++;
      if (nbeats !== 4) begin n_fail++; $display("FAIL bp_count: got %0d required 4", nbeats); end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (got_data[i] !== 32'hA500_0004 + i || got_last[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL bp_beat%0d: data=%h last=%b required %h last=%b",
                     i, got_data[i], got_last[i], 32'hA500_0004 + i, (i == 3));
         end
      end
      n_assert++;
      if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stall cycles, required 0", stall_viol); end
      n_assert++;
      if (max_occ > 2) begin n_fail++; $display("FAIL bp_occupancy: max %0d required <= 2", max_occ); end
   endtask

   task automatic test_fixed;
      int t;
      ar_send(32'h14, 8'd0, 3'd2, 2'b00, t);
      collect(0);
      n_assert++;
      if (nbeats !== 1 || got_data[0] !== 32'hA500_0005 || got_last[0] !== 1'b1 || got_resp[0] !== 2'b00) begin
         n_fail++;
         $display("FAIL fixed_len0: beats=%0d data=%h last=%b resp=%b required 1 A5000005 1 00",
                  nbeats, got_data[0], got_last[0], got_resp[0]);
      end
      ar_send(32'h14, 8'd2, 3'd2, 2'b00, t);
      collect(0);
      n_assert++;
      if (nbeats !== 3) begin n_fail++; $display("FAIL fixed_len2_count: got %0d required 3", nbeats); end
      for (int i = 0; i < 3; i++) begin
         n_assert++;
         if (got_data[i] !== 32'hA500_0005 || got_last[i] !== (i == 2)) begin
            n_fail++;
            $display("FAIL fixed_len2_beat%0d: data=%h last=%b required A5000005 last=%b",
                     i, got_data[i], got_last[i], (i == 2));
         end
      end
   endtask

   task automatic test_error;
      int t;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) ar_send(32'h20, 8'd1, 3'd1, 2'b01, t);
         else        ar_send(32'h20, 8'd1, 3'd2, 2'b10, t);
         collect(0);
         n_assert++;
         if (nbeats !== 2) begin n_fail++; $display("FAIL err%0d_count: got %0d required 2", k, nbeats); end
         for (int i = 0; i < 2; i++) begin
            n_assert++;
            if (got_data[i] !== 32'h0 || got_resp[i] !== 2'b10 || got_last[i] !== (i == 1)) begin
               n_fail++;
               $display("FAIL err%0d_beat%0d: data=%h resp=%b last=%b required 0 10 %b",
                        k, i, got_data[i], got_resp[i], got_last[i], (i == 1));
            end
         end
      end
   endtask

   task automatic test_wrap_around;
      int t;
      logic [31:0] exp_d [4];
      logic [1:0]  exp_r;
`ifdef IMEM_ADDR_RANGE_CHECK_EN
      exp_d[0] = 32'h0; exp_d[1] = 32'h0; exp_d[2] = 32'h0; exp_d[3] = 32'h0;
      exp_r = 2'b11;
`else
      exp_d[0] = 32'hA500_03FE; exp_d[1] = 32'hA500_03FF;
      exp_d[2] = 32'hA500_0000; exp_d[3] = 32'hA500_0001;
      exp_r = 2'b00;
`endif
      ar_send(32'd4 * 32'd1022, 8'd3, 3'd2, 2'b01, t);
      collect(0);
      n_assert++;
      if (nbeats !== 4) begin n_fail++; $display("FAIL edge_count: got %0d required 4", nbeats); end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (got_data[i] !== exp_d[i] || got_resp[i] !== exp_r || got_last[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL edge_beat%0d: data=%h resp=%b last=%b required %h %b %b",
                     i, got_data[i], got_resp[i], got_last[i], exp_d[i], exp_r, (i == 3));
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      int t, cnt, seen;
      ar_send(32'h0, 8'd7, 3'd2, 2'b01, t);
      cnt = 0;
      for (int c = 0; c < 30 && cnt < 3; c++) begin
         @(negedge clk);
         if (rvalid && rready) cnt++;
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_assert++;
      if (rvalid !== 1'b0 || arready !== 1'b0 || mem_en !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_async: rvalid=%b arready=%b en=%b required 0 0 0", rvalid, arready, mem_en);
      end
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rvalid) seen++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      if (rvalid) seen++;
      n_assert++;
      if (seen !== 0 || arready !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_release: stray beats=%0d arready=%b required 0 and 1", seen, arready);
      end
      ar_send(32'h20, 8'd1, 3'd2, 2'b01, t);
      collect(0);
      n_assert++;
      if (nbeats !== 2 || got_data[0] !== 32'hA500_0008 || got_data[1] !== 32'hA500_0009 ||
          got_resp[0] !== 2'b00 || got_last[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_newburst: beats=%0d d0=%h d1=%h required 2 A5000008 A5000009",
                  nbeats, got_data[0], got_data[1]);
      end
   endtask

   initial begin
      for (int k = 0; k < 1024; k++) bram[k] = 32'hA500_0000 + k;
      test_reset();
      test_incr_basic();
      test_backpressure();
      test_fixed();
      test_error();
      test_wrap_around();
      test_reset_mid_burst();
      n_assert++;
      if (aw_viol !== 0) begin
         n_fail++; $display("FAIL write_channel: %0d cycles with aw/w/b active, required 0", aw_viol);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
